alu_seq_nbit: RTL and testbench
===============================

ALU_SEQ_NBIT -- requirements
Module: alu_seq_nbit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits (legal 2..16).
REQ-002 The block SHALL have parameter DIGITS, default 3, number of seven-segment digits; DIGITS SHALL be >= the decimal digit count of 2^(2*WIDTH)-1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 reserved.
REQ-008 start  input  1  request; sampled only in IDLE.
REQ-009 busy  output  1  high from the accept edge until DONE exits.
REQ-010 done  output  1  one-cycle pulse when result, flags and seg are updated.
REQ-011 result  output  2*WIDTH  registered result of the last completed operation.
REQ-012 carry, neg, zero, err  output  1 each  registered flags of the last completed operation.
REQ-013 seg  output  7*DIGITS  active-low segments; seg[7i+6:7i] is decimal digit i (i=0 units); bit order g,f,e,d,c,b,a.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, CONV, DONE; the reset state SHALL be IDLE.
REQ-015 In IDLE with start=1, a, b, op SHALL be captured at that edge (accept edge) and the FSM SHALL enter CALC; later changes on a, b, op SHALL have no effect.
REQ-016 start while busy=1 SHALL be ignored, without queuing.
REQ-017 CALC SHALL last 1 cycle for add, sub, and, or, xor, 111 and for div with b=0; it SHALL last WIDTH cycles for mul (shift-add) and div (restoring).
REQ-018 add: result = a+b zero-extended; carry = bit WIDTH of the sum.
REQ-019 sub: a>=b -> result = a-b, neg=0; a<b -> result = b-a (magnitude), neg=1; carry=0.
REQ-020 mul: result = a*b, full 2*WIDTH bits; carry=0.
REQ-021 div, b!=0: result[WIDTH-1:0] = a/b, result[2*WIDTH-1:WIDTH] = a%b.
REQ-022 and/or/xor: bitwise on WIDTH bits, zero-extended.
REQ-023 div with b=0 or op=111: result=0, err=1, all other flags 0.
REQ-024 zero SHALL be 1 when the displayed value is 0 and err=0.
REQ-025 Displayed value = quotient for div, otherwise the full result.
REQ-026 CONV SHALL run a sequential double-dabble binary-to-BCD conversion over exactly 2*WIDTH cycles, including for err cases.
REQ-027 DONE SHALL last 1 cycle: result, flags and seg update on entry, done=1, then IDLE.
REQ-028 Latency: done SHALL be high in the cycle following edge C+2*WIDTH+1 after the accept edge (C = CALC length).
REQ-029 Display encoding SHALL be: digits 0-9 standard ("0"=1000000, "1"=1111001).
REQ-030 Leading-zero digits above the most significant nonzero digit SHALL be blank (1111111); digit 0 SHALL always be lit.
REQ-031 err=1 SHALL show dash (0111111) on every digit.
REQ-032 result, flags and seg SHALL hold their values between done pulses.

Reset
REQ-033 rst_n=0 at any edge, including mid-CALC or mid-CONV, SHALL abort the operation and drive state to IDLE.
REQ-034 The same reset SHALL drive busy=0, done=0, result=0 and all flags 0.
REQ-035 The same reset SHALL set seg to digit 0 = "0" with all other digits blank.
REQ-036 The first start after rst_n returns high SHALL be accepted normally.

Verification (WIDTH=4, DIGITS=3)
REQ-037 add a=9, b=8 -> done 10 edges after accept; result=17, carry=1; seg = blank, "1", "7".
REQ-038 sub a=3, b=5 -> result=2, neg=1; seg = blank, blank, "2".
REQ-039 mul a=15, b=15 -> done 13 edges after accept; result=225; a second start pulse 5 edges after accept is ignored and produces exactly one done.
REQ-040 div a=13, b=4 -> result=8'h13 (rem 1, quot 3), seg shows "3"; div a=13, b=0 -> err=1, result=0, all digits dash.
REQ-041 rst_n=0 for one edge during a mul CALC -> busy=0, done=0, result=0, seg = "0", and no done pulse follows.
REQ-042 op=111 -> err=1 after 10 edges; xor a=10, b=6 -> result=12, zero=0; xor a=5, b=5 -> zero=1.

Source files
------------

// File: rtl/alu_seq_nbit.sv
// Sequential N-bit ALU: multi-cycle mul/div, followed by a sequential double-dabble
// conversion that drives an active-low seven-segment display of the result.
module alu_seq_nbit #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [2:0]            op,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    result,
    output logic                  carry,
    output logic                  neg,
    output logic                  zero,
    output logic                  err,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int RW    = 2 * WIDTH;
    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(RW);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [7*DIGITS-1:0] SEG_RST = {{(7*DIGITS-7){1'b1}}, 7'b1000000};

    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   opa, opb;
    logic [2:0]         opr;
    logic [RW-1:0]      work;
    logic [WIDTH-1:0]   rem;
    logic [CNT_W-1:0]   cnt;

    logic [RW-1:0]      res_p;
    logic               carry_p, neg_p, zero_p, err_p;
    logic [RW-1:0]      bin;
    logic [BW-1:0]      bcd;

    logic [WIDTH:0]     mul_sum;
    logic [RW-1:0]      mul_next;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_next, quo_next;
    logic [WIDTH:0]     add_sum;

    logic [RW-1:0]      res_c, disp_c;
    logic               carry_c, neg_c, err_c, zero_c, iter_c, calc_last;

    logic [BW-1:0]      bcd_adj;
    logic [BW+RW-1:0]   dd_next;
    logic [7*DIGITS-1:0] seg_c;
    logic               lit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // One shift-add multiply step and one restoring-divide step per CALC cycle
    always_comb begin
        mul_sum   = {1'b0, work[RW-1:WIDTH]} + (work[0] ? {1'b0, opa} : '0);
        mul_next  = {mul_sum, work[WIDTH-1:1]};
        div_shift = {rem, work[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb};
        div_ok    = ~div_trial[WIDTH];
        rem_next  = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_next  = {work[WIDTH-2:0], div_ok};
        add_sum   = {1'b0, opa} + {1'b0, opb};
    end

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        neg_c   = 1'b0;
        err_c   = 1'b0;
        iter_c  = 1'b0;
        case (opr)
            OP_ADD: begin
                res_c   = {{(WIDTH-1){1'b0}}, add_sum};
                carry_c = add_sum[WIDTH];
            end
            OP_SUB: begin
                if (opa >= opb) begin
                    res_c = {{WIDTH{1'b0}}, opa - opb};
                end else begin
                    res_c = {{WIDTH{1'b0}}, opb - opa};
                    neg_c = 1'b1;
                end
            end
            OP_MUL: begin
                res_c  = mul_next;
                iter_c = 1'b1;
            end
            OP_DIV: begin
                if (opb == '0) begin
                    err_c = 1'b1;
                end else begin
                    res_c  = {rem_next, quo_next};
                    iter_c = 1'b1;
                end
            end
            OP_AND:  res_c = {{WIDTH{1'b0}}, opa & opb};
            OP_OR:   res_c = {{WIDTH{1'b0}}, opa | opb};
            OP_XOR:  res_c = {{WIDTH{1'b0}}, opa ^ opb};
            default: err_c = 1'b1;
        endcase
        // The display shows only the quotient for a division
        disp_c    = (opr == OP_DIV) ? {{WIDTH{1'b0}}, res_c[WIDTH-1:0]} : res_c;
        zero_c    = (disp_c == '0) && !err_c;
        calc_last = !iter_c || (cnt == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        dd_next = {bcd_adj, bin} << 1;
    end

    // Blank leading zeros from the top digit down; the units digit is always lit
    always_comb begin
        seg_c = '1;
        lit   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0 || i == 0)
                lit = 1'b1;
            if (err_p)
                seg_c[7*i +: 7] = SEG_DASH;
            else if (lit)
                seg_c[7*i +: 7] = seg7(bcd[4*i +: 4]);
            else
                seg_c[7*i +: 7] = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
            seg    <= SEG_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        opr   <= op;
                        work  <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (calc_last) begin
                        res_p   <= res_c;
                        carry_p <= carry_c;
                        neg_p   <= neg_c;
                        zero_p  <= zero_c;
                        err_p   <= err_c;
                        bin     <= disp_c;
                        bcd     <= '0;
                        cnt     <= '0;
                        state   <= CONV;
                    end else begin
                        work <= (opr == OP_MUL) ? mul_next : {{WIDTH{1'b0}}, quo_next};
                        rem  <= rem_next;
                        cnt  <= cnt + 1'b1;
                    end
                end
                CONV: begin
                    bcd <= dd_next[BW+RW-1:RW];
                    bin <= dd_next[RW-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(RW - 1))
                        state <= DONE;
                end
                DONE: begin
                    result <= res_p;
                    carry  <= carry_p;
                    neg    <= neg_p;
                    zero   <= zero_p;
                    err    <= err_p;
                    seg    <= seg_c;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed bench for alu_seq_nbit (WIDTH=4, DIGITS=3) with hand-computed expectations.
module tb_alu_seq_nbit;

    localparam int W = 4;
    localparam int D = 3;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic [2:0]       op = '0;
    logic             start = 1'b0;
    logic             busy, done, carry, neg, zero, err;
    logic [2*W-1:0]   result;
    logic [7*D-1:0]   seg;

    int total = 0;
    int bad   = 0;
    int lat;
    int extra_done;

    alu_seq_nbit #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .start(start),
        .busy(busy), .done(done), .result(result), .carry(carry), .neg(neg),
        .zero(zero), .err(err), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after the accept edge, and count
    // edges until done. A nonzero extra re-raises start at that edge number.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2:0] ov, input int extra, output int n);
        a = av; b = bv; op = ov; start = 1'b1;
        step();
        start = 1'b0;
        a = '1; b = '0; op = 3'b111;
        chk("busy_after_accept", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
            start = (extra > 0 && n == extra - 1);
        end
        start = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        repeat (20) begin
            step();
            if (done) n++;
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry, neg, zero, err}, 0);
        chk("rst_seg", seg, {BL, BL, S0});
        rst_n = 1'b1;
        step();

        run_op(4'd9, 4'd8, 3'b000, 0, lat);
        chk("add_lat", lat, 10);
        chk("add_res", result, 17);
        chk("add_carry", carry, 1);
        chk("add_zero", zero, 0);
        chk("add_busy", busy, 0);
        chk("add_seg", seg, {BL, S1, S7});
        step();
        chk("add_done_pulse", done, 0);
        chk("add_hold", result, 17);

        run_op(4'd3, 4'd5, 3'b001, 0, lat);
        chk("sub_lat", lat, 10);
        chk("sub_res", result, 2);
        chk("sub_neg", neg, 1);
        chk("sub_carry", carry, 0);
        chk("sub_seg", seg, {BL, BL, S2});

        run_op(4'd15, 4'd15, 3'b010, 5, lat);
        chk("mul_lat", lat, 13);
        chk("mul_res", result, 225);
        chk("mul_flags", {carry, neg, zero, err}, 0);
        chk("mul_seg", seg, {S2, S2, S5});
        drain(extra_done);
        chk("mul_extra_done", extra_done, 0);

        run_op(4'd13, 4'd4, 3'b011, 0, lat);
        chk("div_lat", lat, 13);
        chk("div_res", result, 8'h13);
        chk("div_seg", seg, {BL, BL, S3});
        chk("div_zero", zero, 0);

        run_op(4'd13, 4'd0, 3'b011, 0, lat);
        chk("div0_lat", lat, 10);
        chk("div0_res", result, 0);
        chk("div0_flags", {carry, neg, zero, err}, 4'b0001);
        chk("div0_seg", seg, {DS, DS, DS});

        run_op(4'd7, 4'd2, 3'b111, 0, lat);
        chk("rsv_lat", lat, 10);
        chk("rsv_err", err, 1);
        chk("rsv_res", result, 0);

        run_op(4'd10, 4'd6, 3'b110, 0, lat);
        chk("xor_lat", lat, 10);
        chk("xor_res", result, 12);
        chk("xor_flags", {carry, neg, zero, err}, 0);
        chk("xor_seg", seg, {BL, S1, S2});

        // Reset for one edge in the middle of a multiply
        a = 4'd15; b = 4'd15; op = 3'b010; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res", result, 0);
        chk("abort_flags", {carry, neg, zero, err}, 0);
        chk("abort_seg", seg, {BL, BL, S0});
        drain(extra_done);
        chk("abort_no_done", extra_done, 0);

        run_op(4'd5, 4'd5, 3'b110, 0, lat);
        chk("xor0_lat", lat, 10);
        chk("xor0_res", result, 0);
        chk("xor0_zero", zero, 1);
        chk("xor0_seg", seg, {BL, BL, S0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
